// File: rtl/empacotador_pkg.sv
// Shared types and default parameters for the box-packing stage.
package empacotador_pkg;

  typedef enum logic [1:0] {
    StEsperaCaixa = 2'd0,
    StEnchendo    = 2'd1,
    StFechando    = 2'd2,
    StEnviando    = 2'd3
  } estado_e;

  localparam int unsigned BottlesPerBoxDef = 12;
  localparam int unsigned CloseCyclesDef   = 4;
  localparam int unsigned MaxCaixasDef     = 99;
  localparam int unsigned TimeoutCyclesDef = 8;

endpackage

// File: rtl/empacotador_caixas_contador_saturado.sv
// Generic saturating up-counter with synchronous clear (clear beats increment).
module contador_saturado #(
  parameter int unsigned Width  = 7,
  parameter int unsigned MaxVal = 99
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] Max = Width'(MaxVal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != Max)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/empacotador_caixas.sv
// Box packing sequencer: wait for box, fill, close, hand off; counts shipped boxes.
// Optional hand-off timeout alarm enabled with `define EMPACOTADOR_TIMEOUT_EN.
module empacotador_caixas
  import empacotador_pkg::*;
#(
  parameter int unsigned BottlesPerBox = BottlesPerBoxDef,
  parameter int unsigned CloseCycles   = CloseCyclesDef,
`ifdef EMPACOTADOR_TIMEOUT_EN
  parameter int unsigned TimeoutCycles = TimeoutCyclesDef,
`endif
  parameter int unsigned MaxCaixas     = MaxCaixasDef
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       garrafa_valid_i,
  output logic       garrafa_ready_o,
  input  logic       sensor_caixa_i,
  input  logic       caixa_ready_i,
  output logic       caixa_valid_o,
  output logic       atuador_fechar_o,
  input  logic       zerar_contagem_i,
  output logic [3:0] contagem_garrafas_o,
  output logic [6:0] contagem_caixas_o,
  output logic [1:0] estado_o,
  output logic       led_alarme_o
);

  localparam logic [3:0] BottlesLast = 4'(BottlesPerBox - 1);
  localparam logic [3:0] CloseLast   = 4'(CloseCycles - 1);

  estado_e    state_q, state_d;
  logic [3:0] garrafas_q, garrafas_d;
  logic [3:0] timer_q, timer_d;
  logic       ready_q, ready_d;
  logic       valid_q, valid_d;
  logic       atuador_q, atuador_d;
  logic       bottle_acc, box_acc;

  assign bottle_acc = ready_q & garrafa_valid_i;
  assign box_acc    = valid_q & caixa_ready_i;

  always_comb begin
    state_d    = state_q;
    garrafas_d = garrafas_q;
    timer_d    = timer_q;
    if (bottle_acc) begin
      garrafas_d = garrafas_q + 4'd1;
    end
    unique case (state_q)
      StEsperaCaixa: begin
        if (sensor_caixa_i) state_d = StEnchendo;
      end
      StEnchendo: begin
        timer_d = '0;
        if (bottle_acc && (garrafas_q == BottlesLast)) state_d = StFechando;
      end
      StFechando: begin
        if (timer_q == CloseLast) begin
          state_d = StEnviando;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      StEnviando: begin
        if (box_acc) begin
          state_d    = StEsperaCaixa;
          garrafas_d = '0;
        end
      end
      default: state_d = StEsperaCaixa;
    endcase
    // Ready needs a full cycle in ENCHENDO first, and drops with the box sensor.
    ready_d   = (state_q == StEnchendo) && (state_d == StEnchendo) && sensor_caixa_i;
    atuador_d = (state_d == StFechando);
    valid_d   = (state_d == StEnviando);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEsperaCaixa;
      garrafas_q <= '0;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      atuador_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      garrafas_q <= garrafas_d;
      timer_q    <= timer_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      atuador_q  <= atuador_d;
    end
  end

  contador_saturado #(
    .Width  (7),
    .MaxVal (MaxCaixas)
  ) u_contador_caixas (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (zerar_contagem_i),
    .inc_i   (box_acc),
    .count_o (contagem_caixas_o)
  );

`ifdef EMPACOTADOR_TIMEOUT_EN
  localparam logic [7:0] TimeoutLim = 8'(TimeoutCycles);

  logic [7:0] wait_q, wait_d;
  logic       alarm_q, alarm_d;

  always_comb begin
    wait_d  = wait_q;
    alarm_d = alarm_q;
    if (box_acc) begin
      wait_d  = '0;
      alarm_d = 1'b0;
    end else if ((state_q == StEnviando) && !caixa_ready_i) begin
      if (wait_q != TimeoutLim) wait_d = wait_q + 8'd1;
      alarm_d = alarm_q | (wait_d == TimeoutLim);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      alarm_q <= alarm_d;
    end
  end

  assign led_alarme_o = alarm_q;
`else
  assign led_alarme_o = 1'b0;
`endif

  assign garrafa_ready_o     = ready_q;
  assign caixa_valid_o       = valid_q;
  assign atuador_fechar_o    = atuador_q;
  assign contagem_garrafas_o = garrafas_q;
  assign estado_o            = state_q;

endmodule

// File: tb/tb_empacotador_caixas.sv
// Directed bench for empacotador_caixas; define EMPACOTADOR_TIMEOUT_EN to check the alarm.
module tb_empacotador_caixas;

  logic       clk;
  logic       rst_n;
  logic       garrafa_valid;
  logic       garrafa_ready;
  logic       sensor_caixa;
  logic       caixa_ready;
  logic       caixa_valid;
  logic       atuador_fechar;
  logic       zerar_contagem;
  logic [3:0] contagem_garrafas;
  logic [6:0] contagem_caixas;
  logic [1:0] estado;
  logic       led_alarme;

  int n_checks = 0;
  int n_pass   = 0;

  empacotador_caixas dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .garrafa_valid_i     (garrafa_valid),
    .garrafa_ready_o     (garrafa_ready),
    .sensor_caixa_i      (sensor_caixa),
    .caixa_ready_i       (caixa_ready),
    .caixa_valid_o       (caixa_valid),
    .atuador_fechar_o    (atuador_fechar),
    .zerar_contagem_i    (zerar_contagem),
    .contagem_garrafas_o (contagem_garrafas),
    .contagem_caixas_o   (contagem_caixas),
    .estado_o            (estado),
    .led_alarme_o        (led_alarme)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] st, input string tag);
    for (int i = 0; i < 100 && estado != st; i++) step();
    chk(tag, {30'd0, estado}, {30'd0, st});
  endtask

  initial begin
    rst_n          = 1'b0;
    garrafa_valid  = 1'b0;
    sensor_caixa   = 1'b0;
    caixa_ready    = 1'b0;
    zerar_contagem = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_estado", {30'd0, estado}, 0);
    chk("rst_garrafas", {28'd0, contagem_garrafas}, 0);
    chk("rst_caixas", {25'd0, contagem_caixas}, 0);
    chk("rst_ready", {31'd0, garrafa_ready}, 0);
    chk("rst_valid", {31'd0, caixa_valid}, 0);
    chk("rst_atuador", {31'd0, atuador_fechar}, 0);
    chk("rst_alarme", {31'd0, led_alarme}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_no_box", {30'd0, estado}, 0);

    // First box: sensor rises, bottles offered continuously.
    sensor_caixa  = 1'b1;
    garrafa_valid = 1'b1;
    step();
    chk("enter_enchendo", {30'd0, estado}, 1);
    chk("ready_lat1", {31'd0, garrafa_ready}, 0);
    step();
    chk("ready_lat2", {31'd0, garrafa_ready}, 1);
    chk("no_bottle_yet", {28'd0, contagem_garrafas}, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("fill_%0d", i), {28'd0, contagem_garrafas}, i);
    end
    chk("full_ready_low", {31'd0, garrafa_ready}, 0);
    chk("full_fechando", {30'd0, estado}, 2);
    chk("close_c1", {31'd0, atuador_fechar}, 1);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("close_c%0d", k), {31'd0, atuador_fechar}, 1);
      chk("close_no_valid", {31'd0, caixa_valid}, 0);
    end
    step();
    chk("close_done", {31'd0, atuador_fechar}, 0);
    chk("valid_up", {31'd0, caixa_valid}, 1);
    chk("estado_enviando", {30'd0, estado}, 3);

    // Hand-off back-pressure.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("valid_hold", {31'd0, caixa_valid}, 1);
      chk("caixas_hold", {25'd0, contagem_caixas}, 0);
    end
    caixa_ready = 1'b1;
    step();
    caixa_ready = 1'b0;
    chk("ship1_caixas", {25'd0, contagem_caixas}, 1);
    chk("ship1_garrafas", {28'd0, contagem_garrafas}, 0);
    chk("ship1_estado", {30'd0, estado}, 0);
    chk("ship1_valid", {31'd0, caixa_valid}, 0);

    // Sensor drop mid-fill; ready is registered so the 7th bottle is already in flight.
    for (int i = 0; i < 40 && contagem_garrafas != 4'd6; i++) step();
    chk("reach6", {28'd0, contagem_garrafas}, 6);
    sensor_caixa = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drop_count", {28'd0, contagem_garrafas}, 7);
      chk("drop_ready", {31'd0, garrafa_ready}, 0);
      chk("drop_estado", {30'd0, estado}, 1);
    end
    sensor_caixa = 1'b1;
    step();
    chk("resume_count", {28'd0, contagem_garrafas}, 7);
    chk("resume_ready", {31'd0, garrafa_ready}, 1);
    wait_state(2'd2, "refill_fechando");
    chk("refill_12", {28'd0, contagem_garrafas}, 12);
    wait_state(2'd3, "refill_enviando");
    caixa_ready = 1'b1;
    step();
    caixa_ready = 1'b0;
    chk("ship2_caixas", {25'd0, contagem_caixas}, 2);

    // Ship up to 5 boxes, then clear on the hand-off edge.
    for (int b = 3; b <= 5; b++) begin
      wait_state(2'd3, "ship_more");
      caixa_ready = 1'b1;
      step();
      caixa_ready = 1'b0;
    end
    chk("caixas5", {25'd0, contagem_caixas}, 5);
    wait_state(2'd3, "zerar_enviando");
    caixa_ready    = 1'b1;
    zerar_contagem = 1'b1;
    step();
    caixa_ready    = 1'b0;
    zerar_contagem = 1'b0;
    chk("zerar_wins", {25'd0, contagem_caixas}, 0);
    chk("zerar_estado", {30'd0, estado}, 0);

    // Saturation at 99.
    caixa_ready = 1'b1;
    for (int i = 0; i < 5000 && contagem_caixas != 7'd99; i++) step();
    chk("reach99", {25'd0, contagem_caixas}, 99);
    wait_state(2'd3, "sat_enviando");
    chk("sat_valid", {31'd0, caixa_valid}, 1);
    step();
    caixa_ready = 1'b0;
    chk("sat_caixas", {25'd0, contagem_caixas}, 99);
    chk("sat_estado", {30'd0, estado}, 0);
    chk("sat_garrafas", {28'd0, contagem_garrafas}, 0);

    // Asynchronous reset during closing.
    wait_state(2'd2, "rst_fechando");
    step();
    chk("pre_rst_atuador", {31'd0, atuador_fechar}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_atuador", {31'd0, atuador_fechar}, 0);
    chk("mid_rst_garrafas", {28'd0, contagem_garrafas}, 0);
    chk("mid_rst_caixas", {25'd0, contagem_caixas}, 0);
    chk("mid_rst_estado", {30'd0, estado}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-off timeout.
    wait_state(2'd3, "to_enviando");
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) chk("alarm_before", {31'd0, led_alarme}, 0);
    end
`ifdef EMPACOTADOR_TIMEOUT_EN
    chk("alarm_set", {31'd0, led_alarme}, 1);
`else
    chk("alarm_tied", {31'd0, led_alarme}, 0);
`endif
    chk("to_valid_hold", {31'd0, caixa_valid}, 1);
    caixa_ready = 1'b1;
    step();
    caixa_ready = 1'b0;
    chk("alarm_clear", {31'd0, led_alarme}, 0);
    chk("to_ship", {25'd0, contagem_caixas}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/empacotador_caixas.md
Name: empacotador_caixas

Overview:
- Downstream of the sealing/counting stage: consumes one "sealed bottle" pulse per accepted bottle and packs bottles into boxes of BOTTLES_PER_BOX.
- Sequences box presence, box filling, box closing (timed actuator) and box hand-off to the outbound conveyor over a valid/ready handshake.
- Keeps a saturating count of shipped boxes for the 7-seg display path.

Parameters:
- BOTTLES_PER_BOX, 12, bottles per box (2..15).
- CLOSE_CYCLES, 4, clock cycles the closing actuator stays asserted (1..15).
- MAX_CAIXAS, 99, saturation value of the box counter (must fit 7 bits).
- TIMEOUT_CYCLES, 8, hand-off wait limit (used only with the optional feature).

Ports:
- clk  in  1  block clock; the slow system clock.
- reset  in  1  asynchronous, active-low reset.
- garrafa_valid  in  1  sealed bottle offered (level; held until accepted).
- garrafa_ready  out  1  stage can take a bottle this cycle.
- sensor_caixa  in  1  empty box present at the packing position.
- caixa_ready  in  1  outbound conveyor accepts the closed box.
- caixa_valid  out  1  closed box available for hand-off.
- atuador_fechar  out  1  box-closing actuator drive.
- zerar_contagem  in  1  synchronous clear of the box counter (start of batch).
- contagem_garrafas  out  4  bottles in the current box.
- contagem_caixas  out  7  boxes shipped, saturating.
- estado  out  2  current state encoding.
- led_alarme  out  1  hand-off timeout alarm (constant 0 without the optional feature).

Behaviour:
- Reset (reset=0, asynchronous): state ESPERA_CAIXA. All of the following are 0: contagem_garrafas, contagem_caixas, garrafa_ready, caixa_valid, atuador_fechar, led_alarme, and the close timer. Outputs are registered.
- States and encoding: ESPERA_CAIXA=0, ENCHENDO=1, FECHANDO=2, ENVIANDO=3.
- ESPERA_CAIXA:
  - garrafa_ready=0.
  - When sensor_caixa=1, go to ENCHENDO next cycle.
- ENCHENDO:
  - garrafa_ready=1.
  - A bottle is accepted on any cycle with garrafa_valid & garrafa_ready; contagem_garrafas increments at that edge.
  - When the accepted bottle makes the count BOTTLES_PER_BOX, the next state is FECHANDO and garrafa_ready drops in the same edge. No over-fill is possible.
  - If sensor_caixa falls while count<BOTTLES_PER_BOX, hold: garrafa_ready=0 and the count is retained until the sensor returns. The state stays ENCHENDO.
- FECHANDO:
  - atuador_fechar=1 for exactly CLOSE_CYCLES cycles, then go to ENVIANDO.
  - garrafa_ready=0; offered bottles wait, nothing is lost.
- ENVIANDO:
  - caixa_valid=1 and held until caixa_ready=1.
  - On the edge with caixa_valid & caixa_ready:
    - contagem_caixas increments, saturating at MAX_CAIXAS.
    - contagem_garrafas clears to 0.
    - Next state is ESPERA_CAIXA.
  - caixa_valid must not drop before acceptance.
- Latency:
  - First bottle is accepted 2 cycles after sensor_caixa rises (one cycle to enter ENCHENDO, one cycle for the registered garrafa_ready).
  - Last bottle to caixa_valid = CLOSE_CYCLES+1 cycles.
- zerar_contagem:
  - Clears contagem_caixas only, in any state.
  - If it coincides with a hand-off, the clear wins and the result is 0.
- Saturation: at MAX_CAIXAS the hand-off still completes and the counter stays at MAX_CAIXAS.
- Reset mid-operation: a partially filled box is abandoned and the counters clear.

Optional Feature:
- Macro: EMPACOTADOR_TIMEOUT_EN.
- Defined:
  - In ENVIANDO, a wait counter counts cycles with caixa_ready=0.
  - On reaching TIMEOUT_CYCLES, led_alarme=1 and latches.
  - The alarm clears on a successful hand-off or on reset. The handshake is unaffected.
- Undefined: no counter is built and led_alarme is tied to 0.

Decomposition:
- Shared package empacotador_pkg: the state encoding constants, BOTTLES_PER_BOX, CLOSE_CYCLES, MAX_CAIXAS defaults.
- One natural sub-module: contador_saturado (generic width/max up-counter with sync clear and async active-low reset), used for contagem_caixas.

Test Plan:
- Reset, then sensor_caixa=1 and garrafa_valid held high:
  - garrafa_ready=1 two cycles after sensor_caixa rises.
  - 12 bottles accepted on consecutive cycles.
  - garrafa_ready=0 after the 12th.
  - atuador_fechar=1 for exactly 4 cycles.
  - Then caixa_valid=1.
- caixa_ready held 0 for 5 cycles, then 1 → caixa_valid stable for all 5 waiting cycles; contagem_caixas 0→1 and contagem_garrafas→0 on the accept edge; estado returns to 0.
- sensor_caixa dropped at count 7 for 3 cycles → no bottle accepted during the drop; count stays 7; filling resumes to 12 when the sensor returns.
- Preload 99 boxes, then complete one more box → contagem_caixas stays 99; hand-off completes normally.
- zerar_contagem asserted on the same edge as a hand-off with contagem_caixas=5 → contagem_caixas=0.
- reset pulsed low during FECHANDO (cycle 2 of 4) → atuador_fechar=0 immediately and all counts 0; with EMPACOTADOR_TIMEOUT_EN, caixa_ready held 0 for 8 cycles → led_alarme=1, cleared on the subsequent accept.
